// File: rtl/test_bed.sv
// Simulation result checker: watches data-cache writes, compares the answer region
// against a golden table, counts mismatches and measures run length in cycles.
module test_bed #(
    parameter int                     ANS_NUM   = 16,
    parameter logic [29:0]            BASE_ADDR = 30'd64,
    parameter logic [ANS_NUM*32-1:0]  ANS_VALS  = {ANS_NUM{32'hC0DE_0001}}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] addr,
    input  logic [31:0] data,
    input  logic        wen,
    output logic [7:0]  error_num,
    output logic [15:0] duration,
    output logic        finish
);

    // state | meaning
    // IDLE  | waiting for answer[0]
    // CHECK | waiting for answer[idx]
    // DONE  | all answers taken, counts frozen
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(ANS_NUM - 1);

    state_t      curstate, nextstate;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  error_num_q, error_num_d;
    logic [15:0] duration_q, duration_d;
    logic        finish_q, finish_d;
    logic [31:0] exp_word;
    logic        hit;
    logic        mismatch;

    always_comb begin
        exp_word = '0;
        for (int i = 0; i < ANS_NUM; i++) begin
            if (idx_q == 8'(i)) exp_word = ANS_VALS[i*32 +: 32];
        end
    end

    // idx is held at 0 in IDLE, so this also covers the first answer at BASE_ADDR
    assign hit      = wen && (addr == BASE_ADDR + {22'd0, idx_q});
    assign mismatch = (data !== exp_word);

    always_comb begin
        nextstate   = curstate;
        idx_d       = idx_q;
        error_num_d = error_num_q;
        duration_d  = duration_q;
        finish_d    = finish_q;
        case (curstate)
            IDLE, CHECK: begin
                if (duration_q != 16'hFFFF) duration_d = duration_q + 16'd1;
                if (hit) begin
                    if (mismatch && error_num_q != 8'hFF) error_num_d = error_num_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        nextstate = DONE;
                        finish_d  = 1'b1;
                    end else begin
                        idx_d     = idx_q + 8'd1;
                        nextstate = CHECK;
                    end
                end
            end
            DONE: begin
                finish_d = 1'b1;
            end
            default: begin
                nextstate = IDLE;
                idx_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            curstate    <= IDLE;
            idx_q       <= '0;
            error_num_q <= '0;
            duration_q  <= '0;
            finish_q    <= 1'b0;
        end else begin
            curstate    <= nextstate;
            idx_q       <= idx_d;
            error_num_q <= error_num_d;
            duration_q  <= duration_d;
            finish_q    <= finish_d;
        end
    end

    assign error_num = error_num_q;
    assign duration  = duration_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_test_bed.sv
// Directed bench for test_bed: a 16-answer checker for sequencing cases and a
// 256-answer checker for the saturation cases.
module tb_test_bed;

    localparam logic [31:0] GOLD [16] = '{
        32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001, 32'hCAFE_F00D,
        32'h0BAD_C0DE, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1357_9BDF,
        32'h2468_ACE0, 32'h00C0_FFEE, 32'h5A5A_5A5A, 32'hA5A5_A5A5,
        32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h1111_1111, 32'h7FFF_FFFF
    };

    function automatic logic [511:0] pack_gold();
        logic [511:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p[i*32 +: 32] = GOLD[i];
        return p;
    endfunction

    localparam logic [511:0]  ANS16  = pack_gold();
    localparam logic [8191:0] ANS256 = {256{32'h8000_0001}};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] data = '0;
    logic        wen = 1'b0;
    logic [7:0]  error_num;
    logic [15:0] duration;
    logic        finish;

    logic [29:0] addr2 = '0;
    logic [31:0] data2 = '0;
    logic        wen2 = 1'b0;
    logic [7:0]  error_num2;
    logic [15:0] duration2;
    logic        finish2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    test_bed #(.ANS_NUM(16), .BASE_ADDR(30'd64), .ANS_VALS(ANS16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
        .error_num(error_num), .duration(duration), .finish(finish)
    );

    test_bed #(.ANS_NUM(256), .BASE_ADDR(30'd64), .ANS_VALS(ANS256)) dut2 (
        .clk(clk), .rst(rst), .addr(addr2), .data(data2), .wen(wen2),
        .error_num(error_num2), .duration(duration2), .finish(finish2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
    endtask

    // one write, sampled on the posedge between the two negedges
    task automatic wr(input logic [29:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        data = d;
        wen  = 1'b1;
        @(negedge clk);
        wen  = 1'b0;
    endtask

    // 16 answers, one per 3 cycles; mode 1 corrupts answer[3] and answer[9]
    task automatic run_seq(input int mode);
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            d = GOLD[i];
            if (mode == 1 && i == 3) d = GOLD[3] ^ 32'd1;
            if (mode == 1 && i == 9) d = 32'd0;
            @(negedge clk);
            if (i == 15) chk("finish_before_last", {31'd0, finish}, 32'd0);
            wr(30'd64 + 30'(i), d);
        end
    endtask

    initial begin
        // 1: reset and idle
        do_reset();
        #1;
        chk("rst_state", {30'd0, dut.curstate}, 32'd0);
        chk("rst_dur", {16'd0, duration}, 32'd0);
        repeat (50) @(negedge clk);
        chk("idle_state", {30'd0, dut.curstate}, 32'd0);
        chk("idle_finish", {31'd0, finish}, 32'd0);
        chk("idle_dur50", {16'd0, duration}, 32'd50);

        // 2: all answers correct
        do_reset();
        run_seq(0);
        chk("t2_finish", {31'd0, finish}, 32'd1);
        chk("t2_err", {24'd0, error_num}, 32'd0);
        chk("t2_dur", {16'd0, duration}, 32'd48);
        chk("t2_state", {30'd0, dut.curstate}, 32'd2);
        wr(30'd64, 32'd0);
        repeat (5) @(negedge clk);
        chk("t2_err_frozen", {24'd0, error_num}, 32'd0);
        chk("t2_dur_frozen", {16'd0, duration}, 32'd48);
        chk("t2_finish_held", {31'd0, finish}, 32'd1);

        // 3: two bad answers
        do_reset();
        run_seq(1);
        chk("t3_err", {24'd0, error_num}, 32'd2);
        chk("t3_finish", {31'd0, finish}, 32'd1);

        // 4: out-of-order, duplicate and out-of-region writes ignored
        do_reset();
        wr(30'd70, 32'hBAD0_0000);
        chk("t4_idle_ignored", {30'd0, dut.curstate}, 32'd0);
        wr(30'd64, GOLD[0]);
        wr(30'd64, 32'hBAD0_0001);
        wr(30'd10, 32'hBAD0_0002);
        chk("t4_idx", {24'd0, dut.idx_q}, 32'd1);
        chk("t4_err", {24'd0, error_num}, 32'd0);
        chk("t4_state", {30'd0, dut.curstate}, 32'd1);

        // 5: reset mid-run
        wr(30'd65, ~GOLD[1]);
        wr(30'd66, GOLD[2]);
        wr(30'd67, GOLD[3]);
        wr(30'd68, GOLD[4]);
        chk("t5_idx", {24'd0, dut.idx_q}, 32'd5);
        chk("t5_err", {24'd0, error_num}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t5_rst_err", {24'd0, error_num}, 32'd0);
        chk("t5_rst_dur", {16'd0, duration}, 32'd0);
        chk("t5_rst_state", {30'd0, dut.curstate}, 32'd0);
        chk("t5_rst_idx", {24'd0, dut.idx_q}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_seq(0);
        chk("t5_rerun_err", {24'd0, error_num}, 32'd0);
        chk("t5_rerun_finish", {31'd0, finish}, 32'd1);

        // 6: saturation of duration and error_num
        do_reset();
        repeat (70000) @(negedge clk);
        chk("t6_dur_sat", {16'd0, duration}, 32'h0000_FFFF);
        chk("t6_dur2_sat", {16'd0, duration2}, 32'h0000_FFFF);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            addr2 = 30'd64 + 30'(i);
            data2 = 32'd0;
            wen2  = 1'b1;
            if (i == 128) chk("t6_err_128", {24'd0, error_num2}, 32'd128);
        end
        @(negedge clk);
        wen2 = 1'b0;
        chk("t6_err_sat", {24'd0, error_num2}, 32'd255);
        chk("t6_finish2", {31'd0, finish2}, 32'd1);
        chk("t6_dur2_held", {16'd0, duration2}, 32'h0000_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
